// File: rtl/scoreboard_multiport_if.sv
// Decode/writeback-side bundle for the multi-port register scoreboard.
// master: pipeline control that issues lookups, sets, clears and flushes.
// slave:  the scoreboard itself.
interface scoreboard_multiport_if #(
  parameter int NUM_READ = 2,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
);
  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [NUM_READ-1:0]        rd_pending;
  logic [NUM_READ*CNT_W-1:0]  rd_count;
  logic [NUM_READ-1:0]        rd_stall;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [CNT_W-1:0]           wr_latency;
  logic                       clr_en;
  logic [ADDR_W-1:0]          clr_addr;
  logic                       advance;
  logic                       flush;
  logic [ADDR_W:0]            pending_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_latency, clr_en, clr_addr, advance, flush,
    input  rd_pending, rd_count, rd_stall, pending_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_latency, clr_en, clr_addr, advance, flush,
    output rd_pending, rd_count, rd_stall, pending_count
  );
endinterface

// File: rtl/scoreboard_multiport.sv
// Register scoreboard: per-register pending flag and countdown until the
// in-flight result becomes forwardable. NUM_READ combinational lookup ports,
// one set port (decode), one clear port (writeback), global flush.
module scoreboard_multiport #(
  parameter int NUM_REGS      = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_READ      = 2,
  parameter int CNT_W         = 2,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  scoreboard_multiport_if.slave sb
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [ADDR_W:0]     pc_q, pc_d;
  logic                inc, dec;
  logic                set_hit, clr_hit, writable;

  // Next state per entry: set beats clear beats countdown; flush wipes all.
  // Out-of-range addresses never match a loop index, so they fall out as no-ops.
  always_comb begin
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    inc      = 1'b0;
    dec      = 1'b0;
    set_hit  = 1'b0;
    clr_hit  = 1'b0;
    writable = 1'b0;
    if (sb.flush) begin
      pend_d = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt_d[i] = '0;
      pc_d = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        writable = !(HARDWIRE_ZERO && i == 0);
        set_hit  = writable && sb.wr_en  && (sb.wr_addr  == ADDR_W'(i));
        clr_hit  = writable && sb.clr_en && (sb.clr_addr == ADDR_W'(i));
        if (set_hit) begin
          if (!pend_q[i]) inc = 1'b1;
          pend_d[i] = 1'b1;
          cnt_d[i]  = sb.wr_latency;
        end else if (clr_hit) begin
          if (pend_q[i]) dec = 1'b1;
          pend_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end else if (pend_q[i] && cnt_q[i] != '0 && sb.advance) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
      pc_d = pc_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      pc_q   <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
    end
  end

  // Lookup ports: pure mux over current state; register 0 and unmapped
  // addresses read as all zero.
  always_comb begin
    sb.rd_pending = '0;
    sb.rd_count   = '0;
    sb.rd_stall   = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (sb.rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i) && !(HARDWIRE_ZERO && i == 0)) begin
          sb.rd_pending[k]             = pend_q[i];
          sb.rd_count[k*CNT_W +: CNT_W] = cnt_q[i];
          sb.rd_stall[k]               = pend_q[i] && (cnt_q[i] != '0);
        end
      end
    end
  end

  assign sb.pending_count = pc_q;

endmodule

// File: tb/tb_scoreboard_multiport.sv
// Directed bench for scoreboard_multiport. NUM_REGS is reduced to 20 so that
// addresses 20..31 exercise the unmapped-address path.
module tb_scoreboard_multiport;
  localparam int NUM_REGS = 20;
  localparam int ADDR_W   = 5;
  localparam int NUM_READ = 2;
  localparam int CNT_W    = 2;

  logic clock;
  logic reset;
  int   nchecks;
  int   nerrors;

  scoreboard_multiport_if #(.NUM_READ(NUM_READ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) sb_if ();

  scoreboard_multiport #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ),
    .CNT_W(CNT_W), .HARDWIRE_ZERO(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sb   (sb_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setrd(input int a0, input int a1);
    sb_if.rd_addr[0*ADDR_W +: ADDR_W] = ADDR_W'(a0);
    sb_if.rd_addr[1*ADDR_W +: ADDR_W] = ADDR_W'(a1);
    #1;
  endtask

  task automatic look(input int k, input string tag, input logic ep, input int ec, input logic es);
    chk({tag, ".pend"},  32'(sb_if.rd_pending[k]), 32'(ep));
    chk({tag, ".cnt"},   32'(sb_if.rd_count[k*CNT_W +: CNT_W]), 32'(ec));
    chk({tag, ".stall"}, 32'(sb_if.rd_stall[k]), 32'(es));
  endtask

  task automatic idle();
    sb_if.wr_en  = 1'b0;
    sb_if.clr_en = 1'b0;
    sb_if.flush  = 1'b0;
  endtask

  initial begin
    nchecks = 0;
    nerrors = 0;
    reset = 1'b0;
    sb_if.rd_addr = '0;
    sb_if.wr_en = 1'b0; sb_if.wr_addr = '0; sb_if.wr_latency = '0;
    sb_if.clr_en = 1'b0; sb_if.clr_addr = '0;
    sb_if.advance = 1'b0; sb_if.flush = 1'b0;

    // Reset
    step();
    reset = 1'b1;
    setrd(3, 5);
    look(0, "rst_p0", 1'b0, 0, 1'b0);
    look(1, "rst_p1", 1'b0, 0, 1'b0);
    chk("rst_pc", 32'(sb_if.pending_count), 0);

    // Set reg 5 latency 2, count down with advance
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd5; sb_if.wr_latency = 2'd2;
    step();
    idle();
    setrd(5, 5);
    look(0, "set5_p0", 1'b1, 2, 1'b1);
    look(1, "set5_p1", 1'b1, 2, 1'b1);
    chk("set5_pc", 32'(sb_if.pending_count), 1);
    sb_if.advance = 1'b1;
    step();
    look(0, "adv1", 1'b1, 1, 1'b1);
    step();
    look(0, "adv2", 1'b1, 0, 1'b0);
    step();
    look(0, "adv_sat", 1'b1, 0, 1'b0);
    sb_if.advance = 1'b0;

    // Set 7, then same-cycle set+clear of 7: set wins, count reloads
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd7; sb_if.wr_latency = 2'd3;
    step();
    chk("set7_pc", 32'(sb_if.pending_count), 2);
    sb_if.wr_latency = 2'd1;
    sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd7;
    step();
    idle();
    setrd(5, 7);
    look(1, "setclr7", 1'b1, 1, 1'b1);
    chk("setclr7_pc", 32'(sb_if.pending_count), 2);

    // Clear 7, then clear it again (no-op)
    sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd7;
    step();
    look(1, "clr7", 1'b0, 0, 1'b0);
    chk("clr7_pc", 32'(sb_if.pending_count), 1);
    step();
    idle();
    chk("clr7_again_pc", 32'(sb_if.pending_count), 1);

    // Set 8 while clearing 5: net zero on pending_count
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd8; sb_if.wr_latency = 2'd1;
    sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd5;
    step();
    idle();
    setrd(5, 8);
    look(0, "clr5", 1'b0, 0, 1'b0);
    look(1, "set8", 1'b1, 1, 1'b1);
    chk("net0_pc", 32'(sb_if.pending_count), 1);

    // Set 1,2,3 with latency 0, then flush with a competing set of 4
    sb_if.wr_en = 1'b1; sb_if.wr_latency = 2'd0;
    sb_if.wr_addr = 5'd1; step();
    sb_if.wr_addr = 5'd2; step();
    sb_if.wr_addr = 5'd3; step();
    idle();
    setrd(1, 3);
    look(0, "lat0_r1", 1'b1, 0, 1'b0);
    look(1, "lat0_r3", 1'b1, 0, 1'b0);
    chk("pre_flush_pc", 32'(sb_if.pending_count), 4);
    sb_if.flush = 1'b1;
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd4; sb_if.wr_latency = 2'd2;
    step();
    idle();
    setrd(4, 1);
    look(0, "flush_r4", 1'b0, 0, 1'b0);
    look(1, "flush_r1", 1'b0, 0, 1'b0);
    chk("flush_pc", 32'(sb_if.pending_count), 0);

    // Register 0 hardwired, and an unmapped address
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd0; sb_if.wr_latency = 2'd3;
    step();
    sb_if.wr_addr = 5'd25;
    step();
    idle();
    setrd(0, 25);
    look(0, "reg0", 1'b0, 0, 1'b0);
    look(1, "oor25", 1'b0, 0, 1'b0);
    chk("reg0_oor_pc", 32'(sb_if.pending_count), 0);

    // Reg 9 latency 3 holds with advance low
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd9; sb_if.wr_latency = 2'd3;
    step();
    idle();
    sb_if.advance = 1'b0;
    step(); step(); step(); step();
    setrd(9, 9);
    look(0, "hold9", 1'b1, 3, 1'b1);
    chk("hold9_pc", 32'(sb_if.pending_count), 1);

    // One advance, then reset mid-countdown while a set is also requested
    sb_if.advance = 1'b1;
    step();
    look(0, "adv9", 1'b1, 2, 1'b1);
    reset = 1'b0;
    sb_if.wr_en = 1'b1; sb_if.wr_addr = 5'd10; sb_if.wr_latency = 2'd2;
    step();
    idle();
    sb_if.advance = 1'b0;
    reset = 1'b1;
    setrd(9, 10);
    look(0, "rst9", 1'b0, 0, 1'b0);
    look(1, "rst10", 1'b0, 0, 1'b0);
    chk("rst2_pc", 32'(sb_if.pending_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
